// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - round-robin arbiter sharing one cache port among NUM_CORES cores
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module cache_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [NUM_CORES-1:0]          req_rw,
  input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   req_wdata,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          done,
  output logic [DATA_W-1:0]             rdata,
  output logic                          err,
  output logic                          cache_valid,
  output logic                          cache_rw,
  output logic [ADDR_W-1:0]             cache_addr,
  output logic [DATA_W-1:0]             cache_wdata,
  input  logic                          cache_ready,
  input  logic [DATA_W-1:0]             cache_rdata,
  output logic                          busy,
  output logic [$clog2(NUM_CORES)-1:0]  owner
);

  localparam int OW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [OW-1:0]       owner_q, last_q, pick;
  logic                found;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                abort;
  logic [NUM_CORES-1:0] owner_oh;

  // Search starts just after the last served core so it gets lowest priority.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      j = int'(last_q) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        pick  = OW'(j);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE && found) begin
      cnt_q <= '0;
    end else if (state_q == S_BUSY && !cache_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Abort on the edge that would make cache_valid exceed TIMEOUT cycles.
  assign abort = (state_q == S_BUSY) && !cache_ready && (cnt_q == CW'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_BUSY;
      S_BUSY:  if (cache_ready || abort) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_CORES - 1);
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            owner_q <= pick;
            rw_q    <= req_rw[pick];
            addr_q  <= req_addr[pick*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[pick*DATA_W +: DATA_W];
            err_q   <= 1'b0;
          end
        end
        S_BUSY: begin
          if (cache_ready) begin
            if (rw_q) rdata_q <= cache_rdata;
          end else if (abort) begin
            err_q <= 1'b1;
          end
        end
        S_RESP:  last_q <= owner_q;
        default: ;
      endcase
    end
  end

  assign owner_oh    = NUM_CORES'(1) << owner_q;
  assign gnt         = (state_q == S_BUSY || state_q == S_RESP) ? owner_oh : '0;
  assign done        = (state_q == S_RESP) ? owner_oh : '0;
  assign err         = (state_q == S_RESP) && err_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign owner       = owner_q;
  assign cache_valid = (state_q == S_BUSY);
  assign cache_rw    = rw_q;
  assign cache_addr  = addr_q;
  assign cache_wdata = wdata_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - scoreboard bench for cache_bus_arbiter
module tb_cache_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_rw = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      gnt, done;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              cache_valid, cache_rw;
  logic [AW-1:0]     cache_addr;
  logic [DW-1:0]     cache_wdata;
  logic              cache_ready = 1'b0;
  logic [DW-1:0]     cache_rdata = '0;
  logic              busy;
  logic [1:0]        owner;

  cache_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .cache_valid(cache_valid), .cache_rw(cache_rw), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_ready(cache_ready), .cache_rdata(cache_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  done;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input int core, input logic [DW-1:0] rd, input logic e);
    exp_t x;
    x.done  = N'(1) << core;
    x.rdata = rd;
    x.err   = e;
    return x;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got 0x%0h expected none", done);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_vec", 32'(done), 32'(mon_e.done));
        check("done_rdata", 32'(rdata), 32'(mon_e.rdata));
        check("done_err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  task automatic set_req(input int core, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[core]          = 1'b1;
    req_rw[core]             = rw;
    req_addr[core*AW +: AW]  = a;
    req_wdata[core*DW +: DW] = d;
  endtask

  task automatic wait_done(output int core);
    core = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done !== '0) begin
        for (int b = 0; b < N; b++) if (done[b]) core = b;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL wait_done: got timeout expected done pulse");
  endtask

  initial begin
    int c;
    int prev;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    prev = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cache_valid", 32'(cache_valid), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_err", 32'(err), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Fair rotation with the cache always ready.
    cache_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), DW'(i));
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(order[k], 8'h00, 1'b0));
    for (int k = 0; k < 5; k++) begin
      wait_done(c);
      check("rot_core", 32'(c), 32'(order[k]));
      if (k > 0) check("rot_interval", 32'(cyc - prev), 3);
      prev = cyc;
    end
    @(posedge clk); #1 req_valid = '0; cache_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rot_idle_gnt", 32'(gnt), 0);

    // Single load from core 2.
    cache_rdata = 8'h5C;
    set_req(2, 1'b1, 12'h3A5, 8'h00);
    exp_q.push_back(mk(2, 8'h5C, 1'b0));
    @(posedge clk); @(negedge clk);
    check("load_gnt", 32'(gnt), 32'h4);
    check("load_addr", 32'(cache_addr), 32'h3A5);
    check("load_valid", 32'(cache_valid), 1);
    check("load_rw", 32'(cache_rw), 1);
    check("load_owner", 32'(owner), 2);
    @(negedge clk); cache_ready = 1'b1;
    wait_done(c);
    check("load_core", 32'(c), 2);
    cache_ready = 1'b0;
    @(posedge clk); #1 req_valid = '0;

    // Store from core 1 that drops its request mid-transaction.
    @(negedge clk);
    set_req(1, 1'b0, 12'h010, 8'hA7);
    exp_q.push_back(mk(1, 8'h5C, 1'b0));
    @(posedge clk); @(negedge clk);
    check("store_gnt", 32'(gnt), 32'h2);
    check("store_wdata", 32'(cache_wdata), 32'hA7);
    check("store_rw", 32'(cache_rw), 0);
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("store_wdata_held", 32'(cache_wdata), 32'hA7);
    check("store_valid_held", 32'(cache_valid), 1);
    cache_ready = 1'b1;
    wait_done(c);
    check("store_core", 32'(c), 1);
    cache_ready = 1'b0;

    // Reset while core 3 is in BUSY.
    @(negedge clk);
    set_req(3, 1'b1, 12'h7FF, 8'h00);
    @(posedge clk); @(negedge clk);
    check("rb_gnt", 32'(gnt), 32'h8);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("rb_gnt_zero", 32'(gnt), 0);
    check("rb_valid_zero", 32'(cache_valid), 0);
    check("rb_busy_zero", 32'(busy), 0);
    check("rb_owner_zero", 32'(owner), 0);
    check("rb_addr_zero", 32'(cache_addr), 0);
    check("rb_rdata_zero", 32'(rdata), 0);
    set_req(0, 1'b1, 12'h123, 8'h00);
    cache_rdata = 8'h99;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rb_first_gnt", 32'(gnt), 32'h1);
    exp_q.push_back(mk(0, 8'h99, 1'b0));
    exp_q.push_back(mk(3, 8'h42, 1'b0));
    cache_ready = 1'b1;
    wait_done(c);
    check("rb_core0", 32'(c), 0);
    @(posedge clk); #1 req_valid[0] = 1'b0; cache_rdata = 8'h42;
    wait_done(c);
    check("rb_core3", 32'(c), 3);
    @(posedge clk); #1 req_valid[3] = 1'b0;

    // New requests from cores 0 and 1 arrive during core 0's done cycle.
    @(negedge clk);
    set_req(0, 1'b0, 12'h001, 8'h11);
    exp_q.push_back(mk(0, 8'h42, 1'b0));
    exp_q.push_back(mk(1, 8'h42, 1'b0));
    exp_q.push_back(mk(0, 8'h42, 1'b0));
    wait_done(c);
    check("sim_first", 32'(c), 0);
    set_req(1, 1'b0, 12'h002, 8'h22);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("sim_next_gnt", 32'(gnt), 32'h2);
    wait_done(c);
    check("sim_second", 32'(c), 1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_done(c);
    check("sim_third", 32'(c), 0);
    @(posedge clk); #1 req_valid[0] = 1'b0; cache_ready = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Watchdog: cache never answers.
    begin
      int vcnt;
      vcnt = 0;
      @(negedge clk);
      set_req(2, 1'b1, 12'h0AA, 8'h00);
      exp_q.push_back(mk(2, 8'h42, 1'b1));
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (cache_valid) vcnt++;
        if (done !== '0) break;
      end
      check("to_valid_cycles", 32'(vcnt), 32'(TO));
      @(posedge clk); #1 req_valid[2] = 1'b0;
      set_req(1, 1'b0, 12'h055, 8'h33);
      cache_ready = 1'b1;
      exp_q.push_back(mk(1, 8'h42, 1'b0));
      wait_done(c);
      check("to_next_core", 32'(c), 1);
      @(posedge clk); #1 req_valid[1] = 1'b0; cache_ready = 1'b0;
    end
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    check("final_gnt", 32'(gnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Round-robin arbiter and sequencer sharing one cache port among `NUM_CORES` processor cores. Each core raises a load/store request; the arbiter grants one core at a time, drives the shared cache request lines and holds them until the cache completes. It then returns a one-cycle completion pulse, with read data for loads, to the owning core. It sits between the per-core processors and the shared cache and generates their `gnt`.

## Interface
Parameters:
- `NUM_CORES`, 4, number of requesting cores, 2–8.
- `ADDR_W`, 12, cache address width.
- `DATA_W`, 8, cache data width.
- `TIMEOUT`, 16, watchdog limit in cycles, ≥2. Used only with `ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_CORES  per-core request; held high until that core's `done`.
- `req_rw`  in  NUM_CORES  per-core direction: 1 = load/read, 0 = store/write.
- `req_addr`  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_CORES*DATA_W  per-core store data, packed the same way.
- `gnt`  out  NUM_CORES  one-hot grant to the current owner.
- `done`  out  NUM_CORES  one-cycle completion pulse to the owner.
- `rdata`  out  DATA_W  load data; valid in the `done` cycle.
- `err`  out  1  timeout abort flag; pulses with `done`.
- `cache_valid`  out  1  request to cache.
- `cache_rw`  out  1  direction to cache.
- `cache_addr`  out  ADDR_W  address to cache.
- `cache_wdata`  out  DATA_W  store data to cache.
- `cache_ready`  in  1  cache completion (hit and data ready).
- `cache_rdata`  in  DATA_W  cache read data; sampled when `cache_ready` is high.
- `busy`  out  1  a transaction is in progress.
- `owner`  out  $clog2(NUM_CORES)  index of the current or last owner.

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE: if any `req_valid` bit is set, select the first set bit searching from `last+1` and wrapping modulo `NUM_CORES`. Latch that core's rw, addr and wdata, set `owner`, go to BUSY. If no bit is set, stay in IDLE.
- BUSY:
  - `gnt[owner]`, `busy` and `cache_valid` are high; the cache outputs come from the latched copies.
  - When `cache_ready` is sampled high: if rw=1, capture `cache_rdata` into `rdata`. Go to RESP.
- RESP:
  - `done[owner]` is high for one cycle and `gnt` stays high. Set `last` = `owner`. Go to IDLE.
  - `rdata` holds its previous value after a store.
- Round-robin fairness: the core that was just served has the lowest priority in the next arbitration.
- Requests latched in BUSY are immune to input changes. If `req_valid` drops mid-transaction, the transaction still completes and `done` still pulses.
- `cache_ready` is ignored in IDLE and RESP.
- Reset (asynchronous, mid-operation allowed):
  - State returns to IDLE. `last` = NUM_CORES-1, so core 0 has first priority.
  - All outputs go to 0: `gnt`, `done`, `rdata`, `err`, `cache_*`, `busy`, `owner`.
  - An in-flight transaction is dropped with no `done`.

## Timing
- Request sampled at edge 0 → `gnt` and `cache_valid` high from edge 1.
- `cache_ready` sampled high at edge k (k ≥ 1) → `done` high during the cycle after edge k.
- IDLE is re-entered after edge k+1, so new arbitration happens at edge k+2.
- Minimum occupancy is 3 cycles per transaction, so back-to-back service of different cores is one grant every 3 cycles.
- `cache_valid` never drops between edge 1 and the edge that samples `cache_ready`.
- `gnt` is always one-hot or zero. `done` is one-hot or zero and pulses only for the owner.

## Configuration
- `ARB_TIMEOUT_EN` defined: a cycle counter clears on entry to BUSY and increments each BUSY cycle without `cache_ready`.
  - If the counter reaches TIMEOUT-1 with `cache_ready` still low, the transaction aborts. `cache_valid` has then been high for exactly TIMEOUT cycles.
  - On abort: go to RESP, pulse `done[owner]` and `err` together, and leave `rdata` unchanged.
- `ARB_TIMEOUT_EN` not defined: no counter; BUSY waits indefinitely and `err` is tied to 0.

## Test plan
- Single load: core 2 requests rw=1, addr 0x3A5; cache returns `cache_ready` with rdata 0x5C two cycles after `cache_valid` → `gnt`=0100 and `cache_addr`=0x3A5; `done[2]` pulses once with `rdata`=0x5C.
- Fair rotation: all four cores request continuously after reset; the cache is ready immediately → grant order is 0,1,2,3,0, one grant every 3 cycles.
- Store then drop: core 1 stores 0xA7 to 0x010 and deasserts `req_valid` in BUSY → `cache_wdata`=0xA7 is held until ready; `done[1]` still pulses; `rdata` is unchanged.
- Reset in BUSY: core 3 is granted, then `rst` goes low before `cache_ready` → all outputs are 0 immediately; after release, cores 3 and 0 both request → core 0 is granted first.
- Timeout (macro on, TIMEOUT=16): `cache_ready` stays 0 → `cache_valid` is high for 16 cycles; `done[owner]` and `err` pulse together; the next request is then arbitrated.
- Simultaneous events: core 0's `done` cycle coincides with new requests from cores 0 and 1 → the next grant goes to core 1.
